control32: RTL and testbench

//  Main instruction decoder of the Minisys-1 32-bit MIPS-subset CPU. Decodes opcode and funct

---
 rtl/control32.sv | 73 +++++++
 tb/tb_control32.sv | 137 +++++++++++++
 2 files changed

// File: rtl/control32.sv
// control32: Minisys-1 main instruction decoder; opcode/funct to datapath control strobes, registered one cycle.
module control32 (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic [5:0] Function_opcode,
    output logic       Jrn,
    output logic       RegDST,
    output logic       ALUSrc,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       Branch,
    output logic       nBranch,
    output logic       Jmp,
    output logic       Jal,
    output logic       I_format,
    output logic       Sftmd,
    output logic [1:0] ALUOp
);
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;
    localparam logic [5:0] FN_JR  = 6'b001000;

    logic r_type, i_fmt, lw, sw, beq, bne, j, jal, jr;

    assign r_type = Opcode == 6'b000000;
    assign i_fmt  = Opcode[5:3] == 3'b001;
    assign lw     = Opcode == OP_LW;
    assign sw     = Opcode == OP_SW;
    assign beq    = Opcode == OP_BEQ;
    assign bne    = Opcode == OP_BNE;
    assign j      = Opcode == OP_J;
    assign jal    = Opcode == OP_JAL;
    // funct is only meaningful for R-type, so every funct term is gated by r_type
    assign jr     = r_type && Function_opcode == FN_JR;

    always_ff @(posedge clock) begin
        if (reset) begin
            Jrn      <= 1'b0;
            RegDST   <= 1'b0;
            ALUSrc   <= 1'b0;
            MemtoReg <= 1'b0;
            RegWrite <= 1'b0;
            MemWrite <= 1'b0;
            Branch   <= 1'b0;
            nBranch  <= 1'b0;
            Jmp      <= 1'b0;
            Jal      <= 1'b0;
            I_format <= 1'b0;
            Sftmd    <= 1'b0;
            ALUOp    <= 2'b00;
        end else begin
            Jrn      <= jr;
            RegDST   <= r_type;
            ALUSrc   <= i_fmt | lw | sw;
            MemtoReg <= lw;
            RegWrite <= (r_type | i_fmt | lw | jal) & ~jr;
            MemWrite <= sw;
            Branch   <= beq;
            nBranch  <= bne;
            Jmp      <= j;
            Jal      <= jal;
            I_format <= i_fmt;
            Sftmd    <= r_type && Function_opcode[5:3] == 3'b000;
            ALUOp    <= {r_type | i_fmt, beq | bne};
        end
    end
endmodule

// File: tb/tb_control32.sv
// tb_control32: scoreboard bench for control32; driver queues expected strobes, monitor checks after each edge.
module tb_control32;
    logic       clock = 1'b1;
    logic       reset;
    logic [5:0] Opcode, Function_opcode;
    logic       Jrn, RegDST, ALUSrc, MemtoReg, RegWrite, MemWrite;
    logic       Branch, nBranch, Jmp, Jal, I_format, Sftmd;
    logic [1:0] ALUOp;

    logic [13:0] exp_q[$];
    string       name_q[$];
    int          tests = 0;
    int          fails = 0;

    control32 dut (
        .clock(clock), .reset(reset), .Opcode(Opcode), .Function_opcode(Function_opcode),
        .Jrn(Jrn), .RegDST(RegDST), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .Branch(Branch), .nBranch(nBranch), .Jmp(Jmp), .Jal(Jal),
        .I_format(I_format), .Sftmd(Sftmd), .ALUOp(ALUOp)
    );

    always #5 clock = ~clock;

    // Bit order: Jrn RegDST ALUSrc MemtoReg RegWrite MemWrite Branch nBranch Jmp Jal I_format Sftmd ALUOp[1:0]
    localparam logic [13:0] E_NOP  = 14'b0_0_0_0_0_0_0_0_0_0_0_0_00;
    localparam logic [13:0] E_ADD  = 14'b0_1_0_0_1_0_0_0_0_0_0_0_10;
    localparam logic [13:0] E_JR   = 14'b1_1_0_0_0_0_0_0_0_0_0_0_10;
    localparam logic [13:0] E_SRL  = 14'b0_1_0_0_1_0_0_0_0_0_0_1_10;
    localparam logic [13:0] E_ADDI = 14'b0_0_1_0_1_0_0_0_0_0_1_0_10;
    localparam logic [13:0] E_LW   = 14'b0_0_1_1_1_0_0_0_0_0_0_0_00;
    localparam logic [13:0] E_SW   = 14'b0_0_1_0_0_1_0_0_0_0_0_0_00;
    localparam logic [13:0] E_BEQ  = 14'b0_0_0_0_0_0_1_0_0_0_0_0_01;
    localparam logic [13:0] E_BNE  = 14'b0_0_0_0_0_0_0_1_0_0_0_0_01;
    localparam logic [13:0] E_J    = 14'b0_0_0_0_0_0_0_0_1_0_0_0_00;
    localparam logic [13:0] E_JAL  = 14'b0_0_0_0_1_0_0_0_0_1_0_0_00;

    // Golden model: instruction-by-instruction table
    function automatic logic [13:0] golden(input logic [5:0] op, input logic [5:0] fn);
        logic [13:0] e;
        e = E_NOP;
        if (op == 6'd0) begin
            e = (fn == 6'b001000) ? E_JR : E_ADD;
            e[2] = (fn < 6'd8);
        end else if (op >= 6'd8 && op <= 6'd15) e = E_ADDI;
        else if (op == 6'd35) e = E_LW;
        else if (op == 6'd43) e = E_SW;
        else if (op == 6'd4)  e = E_BEQ;
        else if (op == 6'd5)  e = E_BNE;
        else if (op == 6'd2)  e = E_J;
        else if (op == 6'd3)  e = E_JAL;
        return e;
    endfunction

    task automatic step(input logic r, input logic [5:0] op, input logic [5:0] fn,
                        input logic [13:0] e, input string nm);
        @(negedge clock);
        reset = r;
        Opcode = op;
        Function_opcode = fn;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: every rising edge presents a fresh registered decode
    initial begin
        logic [13:0] got, e;
        string nm;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                nm = name_q.pop_front();
                got = {Jrn, RegDST, ALUSrc, MemtoReg, RegWrite, MemWrite, Branch, nBranch,
                       Jmp, Jal, I_format, Sftmd, ALUOp};
                tests++;
                if (got !== e) begin
                    fails++;
                    $display("FAIL %s: got %b expected %b", nm, got, e);
                end
            end
        end
    end

    initial begin
        int budget;
        reset = 1'b1;
        Opcode = 6'd0;
        Function_opcode = 6'b100000;
        step(1'b1, 6'd0, 6'b100000, E_NOP, "reset0");
        step(1'b1, 6'd0, 6'b100000, E_NOP, "reset1");
        step(1'b0, 6'd0, 6'b100000, E_ADD, "add");
        step(1'b0, 6'd0, 6'b001000, E_JR, "jr");
        step(1'b0, 6'd0, 6'b000010, E_SRL, "srl");
        step(1'b0, 6'b001000, 6'b000000, E_ADDI, "addi");
        step(1'b0, 6'b001000, 6'b001000, E_ADDI, "addi_jrfunct");
        step(1'b0, 6'b001111, 6'b000000, E_ADDI, "lui");
        step(1'b0, 6'b100011, 6'b000000, E_LW, "lw");
        step(1'b0, 6'b101011, 6'b000000, E_SW, "sw");
        step(1'b0, 6'b000100, 6'b000000, E_BEQ, "beq");
        step(1'b0, 6'b000101, 6'b000000, E_BNE, "bne");
        step(1'b0, 6'b000010, 6'b000000, E_J, "j");
        step(1'b0, 6'b000011, 6'b001000, E_JAL, "jal");
        step(1'b0, 6'b100000, 6'b000000, E_NOP, "lb_unlisted");
        step(1'b0, 6'b101010, 6'b000000, E_NOP, "sw_neighbour");
        step(1'b0, 6'b111111, 6'b100000, E_NOP, "op_111111");
        step(1'b0, 6'd0, 6'b100000, E_ADD, "add_before_sw");
        // Inputs wander mid-cycle; only the value at the edge may show up
        step(1'b0, 6'd0, 6'b100000, E_SW, "midcycle_sw");
        #2 Opcode = 6'b101011;
        step(1'b1, 6'b100011, 6'b000000, E_NOP, "reset_mid");
        step(1'b0, 6'b100011, 6'b000000, E_LW, "resume_lw");
        for (int o = 0; o < 64; o++) begin
            logic [5:0] op;
            logic [5:0] fns[3];
            op = o[5:0];
            fns[0] = 6'b001000;
            fns[1] = 6'b100000;
            fns[2] = 6'b000010;
            for (int f = 0; f < 3; f++)
                step(1'b0, op, fns[f], golden(op, fns[f]), $sformatf("sweep_op%0d_fn%0d", o, fns[f]));
        end
        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clock);
            budget--;
        end
        #2;
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
